dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port data memory (dm) between the CPU MEM stage and the debug/loader port.
//  CPU has priority. A wait counter guarantees the debug port a grant within MAX_WAIT cycles.
//  dbg_lock lets the debug port hold dm for a burst while the CPU stalls.
//  Sits between the MEM stage and dm; it drives dm_w/dm_r/dm_addr/dm_wdata/dm_op and returns read data.
// PARAMETERS
//  MAX_WAIT  4  max consecutive cycles dbg_req may be refused before a forced dbg grant (1..7)
//  WAIT_W    3  width of the wait counter; must hold MAX_WAIT
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  cpu_req     in   1   CPU memory access request (MEM stage)
//  cpu_we      in   1   1=store, 0=load
//  cpu_addr    in   32  byte address
//  cpu_wdata   in   32  store data
//  cpu_op      in   3   dm_op access code, passed through unchanged
//  cpu_stall   out  1   cpu_req && !cpu granted this cycle (combinational)
//  cpu_rvalid  out  1   registered; load data valid
//  cpu_rdata   out  32  registered load data
//  dbg_req/dbg_we/dbg_addr[32]/dbg_wdata[32]/dbg_op[3]  in  debug request fields, same meaning as cpu_*
//  dbg_lock    in   1   hold dm for dbg while high
//  dbg_gnt     out  1   dbg granted this cycle (combinational)
//  dbg_rvalid  out  1   registered; load data valid
//  dbg_rdata   out  32  registered load data
//  dm_w, dm_r  out  1   dm write/read strobes
//  dm_addr     out  32  address to dm
//  dm_wdata    out  32  write data to dm
//  dm_op       out  3   access code to dm
//  dm_rdata    in   32  dm read data, combinational from dm_addr/dm_op
// BEHAVIOUR
//  States: NORMAL, LOCK. Reset -> NORMAL, wait_cnt=0, *_rvalid=0, *_rdata=0.
//  Grant is decided combinationally each cycle:
//   NORMAL: dbg wins if dbg_req && (!cpu_req || wait_cnt==MAX_WAIT); otherwise cpu wins if cpu_req.
//   LOCK: dbg wins if dbg_req; cpu never wins (cpu_stall=cpu_req), even if dm is idle.
//  dm_* are a mux of the winner's fields. dm_w = win & we; dm_r = win & !we.
//  With no winner: dm_w=dm_r=0, dm_addr/dm_wdata/dm_op=0.
//  A write commits at the posedge ending the grant cycle.
//  A read samples dm_rdata at that same posedge into the winner's rdata register.
//  The winner's rvalid is high for exactly the next cycle (latency 1).
//  *_rdata holds its last value when rvalid=0.
//  wait_cnt: cleared on a dbg grant or when dbg_req=0.
//   Otherwise it increments, saturating at MAX_WAIT.
//  Transitions: NORMAL->LOCK on a dbg grant with dbg_lock=1.
//   LOCK->NORMAL on any cycle with dbg_lock=0; that cycle is already arbitrated as NORMAL.
//  Boundary cases:
//   Simultaneous req with wait_cnt<MAX_WAIT -> cpu wins. With wait_cnt==MAX_WAIT -> dbg wins, cpu stalls 1 cycle.
//   MAX_WAIT=1 alternates cpu/dbg under continuous contention.
//   Back-to-back reads by the same port pipeline: rvalid stays high on consecutive cycles.
//   rst mid-access: the pending rvalid is dropped (0 the next cycle), state->NORMAL, and no dm strobe is issued in the rst cycle.
//   dbg_lock=1 with dbg_req=0 in NORMAL has no effect.
// STRUCTURE
//  Shared package: DM_OP_W=3, DATA_W=32, ADDR_W=32, state encoding (ST_NORMAL, ST_LOCK).
//  One natural sub-module: dm_arb_port_mux (2:1 field mux + strobe gen).
//  Wait counter, FSM and rdata/rvalid registers stay in the top module.
// TESTING
//  1 cpu load only: cpu_req=1, we=0, addr=0x10; dm holds 0xDEADBEEF -> dm_r=1 same cycle, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
//  2 dbg store then cpu load, same addr 0x20, wdata=0x12345678 -> next cycle cpu_rdata=0x12345678.
//  3 Contention, both req held, MAX_WAIT=4 -> cpu granted cycles 0-3, dbg_gnt=1 in cycle 4 with cpu_stall=1, cpu granted again in cycle 5.
//  4 Lock: dbg_lock=1, dbg writes 3 words while cpu_req=1 -> cpu_stall=1 throughout, including idle gap cycles.
//    Drop dbg_lock -> cpu granted the same cycle.
//  5 rst asserted in the cycle after a cpu read grant -> cpu_rvalid=0, dm_w=dm_r=0 during rst, wait_cnt=0.
//  6 No requests -> dm_w=dm_r=0, dm_addr=0, all rvalid=0.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared widths, FSM encoding and request-field bundle for the data-memory arbiter.
// Used by the arbiter top, its port mux and the dm bus interface.
package dm_arbiter_pkg;

  localparam int unsigned DM_OP_W = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [0:0] {
    StNormal,
    StLock
  } arb_state_e;

  // Access fields of one requester; the request bit itself stays separate.
  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DM_OP_W-1:0] op;
  } port_fields_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Single-port data-memory bus between the arbiter (master) and the dm (slave).
// dm_rdata is combinational from dm_addr/dm_op on the memory side.
interface dm_arbiter_if;
  import dm_arbiter_pkg::*;

  logic               dm_w;
  logic               dm_r;
  logic [ADDR_W-1:0]  dm_addr;
  logic [DATA_W-1:0]  dm_wdata;
  logic [DM_OP_W-1:0] dm_op;
  logic [DATA_W-1:0]  dm_rdata;

  modport master (
    output dm_w,
    output dm_r,
    output dm_addr,
    output dm_wdata,
    output dm_op,
    input  dm_rdata
  );

  modport slave (
    input  dm_w,
    input  dm_r,
    input  dm_addr,
    input  dm_wdata,
    input  dm_op,
    output dm_rdata
  );

endinterface

// File: rtl/dm_arb_port_mux.sv
// 2:1 mux of the winning requester's fields onto the dm bus, plus read/write strobes.
// With no winner every dm output is driven to zero.
module dm_arb_port_mux
  import dm_arbiter_pkg::*;
(
  input  port_fields_t       cpu,
  input  port_fields_t       dbg,
  input  logic               cpu_win,
  input  logic               dbg_win,
  output logic               dm_w,
  output logic               dm_r,
  output logic [ADDR_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  dm_wdata,
  output logic [DM_OP_W-1:0] dm_op
);

  port_fields_t sel;
  logic         any_win;

  always_comb begin
    sel = '0;
    if (dbg_win) begin
      sel = dbg;
    end else if (cpu_win) begin
      sel = cpu;
    end
  end

  assign any_win  = cpu_win | dbg_win;
  assign dm_w     = any_win & sel.we;
  assign dm_r     = any_win & ~sel.we;
  assign dm_addr  = sel.addr;
  assign dm_wdata = sel.wdata;
  assign dm_op    = sel.op;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the data memory between the CPU MEM stage (priority) and the debug/loader port.
// A saturating wait counter bounds debug starvation; dbg_lock holds dm for debug bursts.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic [DM_OP_W-1:0] cpu_op,
  output logic               cpu_stall,
  output logic               cpu_rvalid,
  output logic [DATA_W-1:0]  cpu_rdata,

  input  logic               dbg_req,
  input  logic               dbg_we,
  input  logic [ADDR_W-1:0]  dbg_addr,
  input  logic [DATA_W-1:0]  dbg_wdata,
  input  logic [DM_OP_W-1:0] dbg_op,
  input  logic               dbg_lock,
  output logic               dbg_gnt,
  output logic               dbg_rvalid,
  output logic [DATA_W-1:0]  dbg_rdata,

  dm_arbiter_if.master       dm
);

  localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);

  arb_state_e         state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic               cpu_rvalid_q;
  logic               dbg_rvalid_q;
  logic [DATA_W-1:0]  cpu_rdata_q;
  logic [DATA_W-1:0]  dbg_rdata_q;

  logic               lock_mode;
  logic               cpu_win;
  logic               dbg_win;
  port_fields_t       cpu_fields;
  port_fields_t       dbg_fields;

  // Dropping dbg_lock takes effect in the same cycle, so that cycle arbitrates as normal.
  always_comb begin
    lock_mode = (state_q == StLock) && dbg_lock;
    cpu_win   = 1'b0;
    dbg_win   = 1'b0;
    if (!rst) begin
      if (lock_mode) begin
        dbg_win = dbg_req;
      end else begin
        dbg_win = dbg_req && (!cpu_req || (wait_cnt_q == WaitMax));
        cpu_win = cpu_req && !dbg_win;
      end
    end
  end

  assign cpu_stall  = cpu_req && !cpu_win;
  assign dbg_gnt    = dbg_win;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

  assign cpu_fields = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, op: cpu_op};
  assign dbg_fields = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata, op: dbg_op};

  dm_arb_port_mux u_port_mux (
    .cpu      (cpu_fields),
    .dbg      (dbg_fields),
    .cpu_win  (cpu_win),
    .dbg_win  (dbg_win),
    .dm_w     (dm.dm_w),
    .dm_r     (dm.dm_r),
    .dm_addr  (dm.dm_addr),
    .dm_wdata (dm.dm_wdata),
    .dm_op    (dm.dm_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StNormal;
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_win && !cpu_we;
      dbg_rvalid_q <= dbg_win && !dbg_we;
      if (cpu_win && !cpu_we) begin
        cpu_rdata_q <= dm.dm_rdata;
      end
      if (dbg_win && !dbg_we) begin
        dbg_rdata_q <= dm.dm_rdata;
      end

      if (dbg_win || !dbg_req) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WaitMax) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end

      case (state_q)
        StNormal: if (dbg_win && dbg_lock) state_q <= StLock;
        StLock:   if (!dbg_lock) state_q <= StNormal;
        default:  state_q <= StNormal;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized and directed bench for dm_arbiter against a cycle-level reference model
// built from the arbitration rules, with a small behavioural data memory on the dm bus.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               cpu_req, cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic [DM_OP_W-1:0] cpu_op;
  logic               cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0]  cpu_rdata;
  logic               dbg_req, dbg_we, dbg_lock;
  logic [ADDR_W-1:0]  dbg_addr;
  logic [DATA_W-1:0]  dbg_wdata;
  logic [DM_OP_W-1:0] dbg_op;
  logic               dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0]  dbg_rdata;

  dm_arbiter_if dm ();

  dm_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_op     (cpu_op),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_op     (dbg_op),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dm         (dm)
  );

  // Behavioural single-port memory: combinational read, write on posedge.
  logic [DATA_W-1:0] dm_mem [64];
  assign dm.dm_rdata = dm_mem[dm.dm_addr[7:2]];
  always @(posedge clk) if (dm.dm_w) dm_mem[dm.dm_addr[7:2]] <= dm.dm_wdata;

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [64];
  int                m_wait;
  bit                m_lock;
  bit                m_crv, m_drv;
  logic [DATA_W-1:0] m_crd, m_drd;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs: predict, check at negedge, advance model.
  task automatic cycle();
    bit lock_eff, dwin, cwin, e_w, e_r;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_op;
    lock_eff = m_lock && dbg_lock;
    dwin = 1'b0;
    cwin = 1'b0;
    if (!rst) begin
      if (lock_eff) dwin = dbg_req;
      else begin
        dwin = dbg_req && (!cpu_req || m_wait == MAX_WAIT);
        cwin = cpu_req && !dwin;
      end
    end
    e_addr = 0; e_wdata = 0; e_op = 0;
    if (dwin) begin e_addr = dbg_addr; e_wdata = dbg_wdata; e_op = dbg_op; end
    else if (cwin) begin e_addr = cpu_addr; e_wdata = cpu_wdata; e_op = cpu_op; end
    e_w = (cwin && cpu_we) || (dwin && dbg_we);
    e_r = (cwin && !cpu_we) || (dwin && !dbg_we);

    @(negedge clk);
    chk("cpu_stall",  cpu_stall,   cpu_req && !cwin);
    chk("dbg_gnt",    dbg_gnt,     dwin);
    chk("dm_w",       dm.dm_w,     e_w);
    chk("dm_r",       dm.dm_r,     e_r);
    chk("dm_addr",    dm.dm_addr,  e_addr);
    chk("dm_wdata",   dm.dm_wdata, e_wdata);
    chk("dm_op",      dm.dm_op,    e_op);
    chk("cpu_rvalid", cpu_rvalid,  m_crv);
    chk("cpu_rdata",  cpu_rdata,   m_crd);
    chk("dbg_rvalid", dbg_rvalid,  m_drv);
    chk("dbg_rdata",  dbg_rdata,   m_drd);

    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_lock = 0; m_crv = 0; m_drv = 0; m_crd = 0; m_drd = 0;
    end else begin
      m_crv = cwin && !cpu_we;
      m_drv = dwin && !dbg_we;
      if (m_crv) m_crd = ref_mem[e_addr[7:2]];
      if (m_drv) m_drd = ref_mem[e_addr[7:2]];
      if (e_w) ref_mem[e_addr[7:2]] = e_wdata;
      if (dwin || !dbg_req) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (!lock_eff) m_lock = dwin && dbg_lock;
    end
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_op = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_op = 0; dbg_lock = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      dm_mem[i] <= 32'h1000_0000 + 32'(i * 32'h0101);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 32'h0101);
    end
    dm_mem[4] <= 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    m_wait = 0; m_lock = 0; m_crv = 0; m_drv = 0; m_crd = 0; m_drd = 0;
    @(posedge clk);
    #1;

    // Reset, then idle bus.
    cycle();
    rst = 1'b0;
    cycle();
    chk("idle_dm_addr", dm.dm_addr, 32'h0);
    chk("idle_dm_r", dm.dm_r, 1'b0);

    // CPU load only.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_op = 3'd2;
    #1 chk("t1_dm_r", dm.dm_r, 1'b1);
    cycle();
    idle_inputs();
    chk("t1_rvalid", cpu_rvalid, 1'b1);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cycle();

    // Debug store, then CPU load of the same word.
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678; dbg_op = 3'd2;
    cycle();
    idle_inputs();
    cpu_req = 1; cpu_addr = 32'h20;
    cycle();
    idle_inputs();
    chk("t2_rdata", cpu_rdata, 32'h1234_5678);
    cycle();

    // Sustained contention: CPU for MAX_WAIT cycles, then one forced debug grant.
    cpu_req = 1; cpu_addr = 32'h4; dbg_req = 1; dbg_addr = 32'h8;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_dbg_gnt", dbg_gnt, (i == 4));
      cycle();
      chk("t3_dbg_rvalid", dbg_rvalid, (i == 4));
      chk("t3_cpu_rvalid", cpu_rvalid, (i != 4));
    end
    idle_inputs();
    cycle();

    // Locked debug burst of three writes with an idle gap; CPU stalls throughout.
    dbg_lock = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'hA5A5_0001;
    cycle();
    cpu_req = 1; cpu_addr = 32'h30; dbg_req = 0;
    #1 chk("t4_stall_gap", cpu_stall, 1'b1);
    cycle();
    for (int i = 0; i < 2; i++) begin
      dbg_req = 1; dbg_addr = 32'h34 + 32'(i * 4); dbg_wdata = 32'hA5A5_0002 + 32'(i);
      #1 chk("t4_stall_burst", cpu_stall, 1'b1);
      cycle();
    end
    dbg_req = 0; dbg_lock = 0;
    #1 chk("t4_unlock_stall", cpu_stall, 1'b0);
    cycle();
    idle_inputs();
    chk("t4_cpu_rdata", cpu_rdata, 32'hA5A5_0001);
    cycle();

    // Reset right after a CPU read grant, with contention building the wait count.
    cpu_req = 1; cpu_addr = 32'h10; dbg_req = 1;
    cycle();
    cycle();
    rst = 1;
    #1 chk("t5_dm_r_rst", dm.dm_r, 1'b0);
    cycle();
    rst = 0;
    chk("t5_rvalid_after_rst", cpu_rvalid, 1'b0);
    for (int i = 0; i < 6; i++) cycle();
    idle_inputs();
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = 32'($urandom_range(0, 15)) << 2;
      cpu_wdata = $urandom;
      cpu_op    = 3'($urandom_range(0, 7));
      dbg_req   = ($urandom_range(0, 2) != 0);
      dbg_we    = $urandom_range(0, 1);
      dbg_addr  = 32'($urandom_range(0, 15)) << 2;
      dbg_wdata = $urandom;
      dbg_op    = 3'($urandom_range(0, 7));
      dbg_lock  = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
